// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl
// Resolves RV32I conditional branches issued from EX. A request is accepted in
// IDLE, the comparator result is sampled one cycle later (EVAL), and the
// outcome is published one cycle after that. A taken branch raises a one-cycle
// fetch redirect and holds flush_o for FLUSH_CYCLES cycles before the
// controller becomes ready again.
//
// Optional feature: define BRANCH_RESOLVE_STATS_EN to add the saturating
// resolution counters stat_total / stat_taken.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   br_valid / br_ready   request handshake (ready only while IDLE)
//   br_funct3/pc/imm      branch descriptor, captured on accept
//   kill                  abort from an older exception
//   brun                  unsigned-compare select to the comparator (EVAL only)
//   breq, brlt            comparator results, sampled in EVAL
//   resolve_valid, taken  resolution pulse and outcome
//   illegal               pulse with resolve_valid for funct3 010/011
//   redirect_valid/pc     fetch redirect pulse and target
//   flush_o               flush IF/ID and ID/EX
//   stat_total/stat_taken resolution counters (macro-enabled only)
module branch_resolve_ctrl #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        br_valid,
    output logic        br_ready,
    input  logic [2:0]  br_funct3,
    input  logic [31:0] br_pc,
    input  logic [31:0] br_imm,
    input  logic        kill,
    output logic        brun,
    input  logic        breq,
    input  logic        brlt,
    output logic        resolve_valid,
    output logic        taken,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush_o,
`ifdef BRANCH_RESOLVE_STATS_EN
    output logic [15:0] stat_total,
    output logic [15:0] stat_taken,
`endif
    output logic        illegal
);

    typedef enum logic [1:0] {IDLE, EVAL, FLUSH} state_t;

    state_t      stateReg, stateNext;
    logic [2:0]  flushCntReg, flushCntNext;
    logic [2:0]  funct3Reg;
    logic [31:0] pcReg;
    logic [31:0] immReg;
    logic        accept;
    logic        cond;
    logic        isIllegal;
    logic        evalDone;

    assign br_ready  = (stateReg == IDLE);
    assign accept    = br_valid && br_ready && !kill;
    assign brun      = (stateReg == EVAL) && funct3Reg[2] && funct3Reg[1];
    assign flush_o   = (stateReg == FLUSH);
    assign isIllegal = (funct3Reg == 3'b010) || (funct3Reg == 3'b011);
    // A branch is resolved only if it leaves EVAL without being killed.
    assign evalDone  = (stateReg == EVAL) && !kill;

    always_comb begin
        cond = 1'b0;
        case (funct3Reg)
            3'b000:  cond = breq;
            3'b001:  cond = !breq;
            3'b100:  cond = brlt;
            3'b110:  cond = brlt;
            3'b101:  cond = !brlt;
            3'b111:  cond = !brlt;
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        stateNext    = stateReg;
        flushCntNext = flushCntReg;
        case (stateReg)
            IDLE: begin
                if (accept) stateNext = EVAL;
            end
            EVAL: begin
                if (kill) begin
                    stateNext = IDLE;
                end else if (cond) begin
                    stateNext    = FLUSH;
                    // Counter holds the number of flush cycles still to follow.
                    flushCntNext = 3'(FLUSH_CYCLES - 1);
                end else begin
                    stateNext = IDLE;
                end
            end
            FLUSH: begin
                if (kill || flushCntReg == 3'd0) begin
                    stateNext    = IDLE;
                    flushCntNext = 3'd0;
                end else begin
                    flushCntNext = flushCntReg - 3'd1;
                end
            end
            default: begin
                stateNext    = IDLE;
                flushCntNext = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg    <= IDLE;
            flushCntReg <= 3'd0;
        end else begin
            stateReg    <= stateNext;
            flushCntReg <= flushCntNext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            funct3Reg <= 3'd0;
            pcReg     <= 32'h0;
            immReg    <= 32'h0;
        end else if (accept) begin
            funct3Reg <= br_funct3;
            pcReg     <= br_pc;
            immReg    <= br_imm;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resolve_valid  <= 1'b0;
            illegal        <= 1'b0;
            taken          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'h0;
        end else begin
            resolve_valid  <= evalDone;
            illegal        <= evalDone && isIllegal;
            redirect_valid <= evalDone && cond;
            if (evalDone) taken <= cond;
            if (evalDone && cond) redirect_pc <= pcReg + immReg;
        end
    end

`ifdef BRANCH_RESOLVE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_total <= 16'h0;
            stat_taken <= 16'h0;
        end else if (evalDone) begin
            if (stat_total != 16'hFFFF) stat_total <= stat_total + 16'd1;
            if (cond && stat_taken != 16'hFFFF) stat_taken <= stat_taken + 16'd1;
        end
    end
`endif

endmodule
